// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// ---------------------------------------------------------------------------
// Memory-stage access controller between the EX/MEM pipeline register and a
// request/acknowledge data-memory bus. Each load or store leaving EX/MEM
// becomes one bus transaction. The pipeline is stalled until that
// transaction finishes, so upstream registers use enable = ~stall.
//
// Bus handshake: bus_req is raised on the edge that leaves IDLE. It stays
// high, with bus_we/bus_addr/bus_wdata frozen, until the edge on which
// bus_ack is seen in WAIT or the wait budget runs out. bus_ack is looked at
// only in WAIT, and bus_rdata is taken only in the cycle bus_ack is high.
//
// Ports:
//   clk, reset                   clock, async active-high reset
//   mem_read_in, mem_write_in    EX/MEM load / store request (store wins)
//   alu_result_in, rs2_data_in   access address / store data
//   bus_req, bus_we              registered request, 1 = write
//   bus_addr, bus_wdata          registered address / store data
//   bus_ack, bus_rdata           completion and read data from memory
//   stall                        combinational pipeline hold
//   load_data_out, load_valid    captured read data, one-cycle completion pulse
//   bus_error                    sticky timeout flag
//   state_dbg                    current FSM state (0 IDLE, 1 WAIT, 2 DONE)
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] rs2_data_in,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] load_data_out,
  output logic        load_valid,
  output logic        bus_error,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // The counter reads 0 in the first WAIT cycle, so the last allowed WAIT
  // cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt;
  logic            req;
  logic            last_wait;
  logic            stall_c;

  assign req       = mem_read_in | mem_write_in;
  assign last_wait = (wait_cnt == LAST_WAIT);
  assign state_dbg = state_q;

  // The IDLE-with-request term depends on raw inputs. Masking it with reset
  // keeps stall low for the whole time reset is held.
  assign stall = stall_c & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          stall_c = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (bus_ack || last_wait) state_d = S_DONE;
      end
      // Requests seen here still belong to the access that just finished.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_req       <= 1'b0;
      bus_we        <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      load_data_out <= '0;
      load_valid    <= 1'b0;
      bus_error     <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      load_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write_in;
            bus_addr  <= alu_result_in;
            bus_wdata <= rs2_data_in;
            wait_cnt  <= '0;
          end
        end
        S_WAIT: begin
          if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CW'(1);
          // An ack on the last allowed cycle still counts as a normal completion.
          if (bus_ack) begin
            bus_req    <= 1'b0;
            load_valid <= 1'b1;
            if (!bus_we) load_data_out <= bus_rdata;
          end else if (last_wait) begin
            bus_req    <= 1'b0;
            bus_error  <= 1'b1;
            load_valid <= 1'b1;
            if (!bus_we) load_data_out <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small reference model and an
// expected-result queue for completed accesses.
module tb_mem_access_ctrl;

  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic        mem_read_in, mem_write_in;
  logic [31:0] alu_result_in, rs2_data_in;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] load_data_out;
  logic        load_valid;
  logic        bus_error;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] load_model = '0;
  logic        err_model  = 1'b0;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read_in   (mem_read_in),
    .mem_write_in  (mem_write_in),
    .alu_result_in (alu_result_in),
    .rs2_data_in   (rs2_data_in),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .stall         (stall),
    .load_data_out (load_data_out),
    .load_valid    (load_valid),
    .bus_error     (bus_error),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full access starting in an IDLE cycle. k = WAIT cycle carrying the
  // ack (1..TMO), or 0 for no ack at all (timeout).
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rdata, input int k);
    logic read_op;
    read_op = rd & ~wr;
    if (read_op) load_model = (k == 0) ? 32'h0 : rdata;
    if (k == 0) err_model = 1'b1;
    exp_q.push_back(load_model);

    mem_read_in   = rd;
    mem_write_in  = wr;
    alu_result_in = addr;
    rs2_data_in   = data;
    bus_ack       = 1'b0;
    #1;
    check("idle_req_stall", stall, 1);
    step();
    for (int i = 1; i <= TMO; i++) begin
      check("wait_bus_req", bus_req, 1);
      check("wait_bus_addr", bus_addr, addr);
      check("wait_bus_we", bus_we, wr);
      check("wait_bus_wdata", bus_wdata, data);
      check("wait_stall", stall, 1);
      check("wait_no_valid", load_valid, 0);
      if (i == k) begin
        bus_ack   = 1'b1;
        bus_rdata = rdata;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
      end
      step();
      if (i == k) break;
    end
    // DONE cycle: request inputs still asserted, a stray ack must be ignored
    bus_ack   = 1'b1;
    bus_rdata = $urandom;
    #1;
    check("done_valid", load_valid, 1);
    check("done_stall", stall, 0);
    check("done_bus_req", bus_req, 0);
    check("done_bus_error", bus_error, err_model);
    check("done_state", state_dbg, 2);
    check("done_load_data", load_data_out, exp_q.pop_front());
    step();
    bus_ack      = 1'b0;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    #1;
    check("post_valid_low", load_valid, 0);
    check("post_bus_req", bus_req, 0);
    check("post_stall", stall, 0);
    check("post_state", state_dbg, 0);
    check("post_load_data", load_data_out, load_model);
  endtask

  initial begin
    reset = 1'b1;
    mem_read_in = 0; mem_write_in = 0; alu_result_in = 0; rs2_data_in = 0;
    bus_ack = 0; bus_rdata = 0;

    // reset with random inputs: all outputs held at zero
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_read_in   = 1'($urandom_range(0, 1));
      mem_write_in  = 1'($urandom_range(0, 1));
      alu_result_in = $urandom;
      rs2_data_in   = $urandom;
      bus_ack       = 1'($urandom_range(0, 1));
      bus_rdata     = $urandom;
      #1;
      check("rst_bus_req", bus_req, 0);
      check("rst_bus_we", bus_we, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_wdata", bus_wdata, 0);
      check("rst_stall", stall, 0);
      check("rst_load_data", load_data_out, 0);
      check("rst_load_valid", load_valid, 0);
      check("rst_bus_error", bus_error, 0);
      check("rst_state", state_dbg, 0);
    end
    step();
    reset = 1'b0;
    mem_read_in = 0; mem_write_in = 0; bus_ack = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("idle_stall", stall, 0);
      check("idle_bus_req", bus_req, 0);
    end

    // load, ack in first WAIT cycle
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    // store, ack on third WAIT cycle
    do_access(1'b0, 1'b1, 32'h20, 32'h12345678, 32'hCAFEF00D, 3);

    // ack in IDLE without a request is ignored
    bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
    step();
    check("idle_ack_valid", load_valid, 0);
    check("idle_ack_bus_req", bus_req, 0);
    check("idle_ack_load_data", load_data_out, load_model);
    bus_ack = 1'b0;

    // ack on the last allowed WAIT cycle: normal completion
    do_access(1'b1, 1'b0, 32'h44, 32'h0, 32'h0BADC0DE, TMO);
    check("last_ack_no_error", bus_error, 0);
    // timeout on a load
    do_access(1'b1, 1'b0, 32'h80, 32'h0, 32'h11111111, 0);
    check("timeout_error_set", bus_error, 1);
    // following load completes while the error stays sticky
    do_access(1'b1, 1'b0, 32'h84, 32'h0, 32'h87654321, 2);
    check("error_sticky", bus_error, 1);
    // read and write together: write wins, load data untouched
    do_access(1'b1, 1'b1, 32'hC0, 32'hA5A5A5A5, 32'hFFFF0000, 1);

    // random accesses
    for (int n = 0; n < 8; n++) begin
      logic rd, wr;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      do_access(rd, wr, $urandom, $urandom, $urandom, $urandom_range(0, TMO));
    end

    // reset asserted mid-WAIT
    mem_read_in = 1'b1; alu_result_in = 32'h300;
    step();
    check("mid_wait_req", bus_req, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_bus_req", bus_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_state", state_dbg, 0);
    mem_read_in = 1'b0;
    step();
    step();
    reset = 1'b0;
    load_model = '0;
    err_model  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("after_rst_no_valid", load_valid, 0);
      check("after_rst_error", bus_error, err_model);
      check("after_rst_bus_req", bus_req, 0);
    end
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller sitting between the EX/MEM pipeline register and a handshaked data-memory bus. It turns each load/store leaving EX/MEM into a single bus transaction with request/acknowledge, and drives `stall` so upstream pipeline registers hold (`enable = ~stall`) until the transaction completes. It captures load data and flags bus timeouts.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum WAIT cycles allowed for `bus_ack`; must be ≥1.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs immediately.
- `mem_read_in`  in  1  EX/MEM load request.
- `mem_write_in`  in  1  EX/MEM store request.
- `alu_result_in`  in  32  access address.
- `rs2_data_in`  in  32  store data.
- `bus_req`  out  1  registered bus request.
- `bus_we`  out  1  registered: 1 = write, 0 = read.
- `bus_addr`  out  32  registered address, stable while `bus_req` = 1.
- `bus_wdata`  out  32  registered store data, stable while `bus_req` = 1.
- `bus_ack`  in  1  completion from memory; sampled only in WAIT.
- `bus_rdata`  in  32  read data, valid with `bus_ack`.
- `stall`  out  1  combinational; 1 = hold pipeline registers.
- `load_data_out`  out  32  registered captured read data.
- `load_valid`  out  1  registered one-cycle pulse at access completion (reads and writes).
- `bus_error`  out  1  registered sticky timeout flag.

## Operation
- States: IDLE, WAIT, DONE. Reset → IDLE.
- IDLE, no request (`mem_read_in` = `mem_write_in` = 0): `stall` = 0, stay IDLE.
- IDLE, request seen: `stall` = 1 that cycle; on the edge, latch `bus_addr` ← `alu_result_in`, `bus_wdata` ← `rs2_data_in`, `bus_we` ← `mem_write_in`, set `bus_req` = 1, clear wait counter, → WAIT.
- Read and write both asserted: write wins (`bus_we` = 1). Read is not performed.
- WAIT: `stall` = 1; `bus_req`, `bus_we`, `bus_addr`, `bus_wdata` held constant; wait counter increments each cycle.
- WAIT with `bus_ack` = 1: drop `bus_req`; if `bus_we` = 0, `load_data_out` ← `bus_rdata`; `load_valid` ← 1; → DONE.
- WAIT timeout: if the wait counter indicates the TIMEOUT_CYCLES-th WAIT cycle and `bus_ack` = 0, drop `bus_req`, set `bus_error` = 1, set `load_data_out` ← 0 on reads, set `load_valid` ← 1, → DONE. An ack in that same cycle is a normal completion, not a timeout.
- DONE: `stall` = 0, so the pipeline advances exactly once. `load_valid` = 0 on the next edge. → IDLE unconditionally. The request inputs in the DONE cycle belong to the completed access and are ignored.
- `bus_ack` in IDLE or DONE is ignored and has no effect.
- `bus_error` stays set until `reset`. Later accesses proceed normally.
- Wait counter width is `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.

## Timing
- Reset values: state IDLE, `bus_req` 0, `bus_we` 0, `bus_addr` 0, `bus_wdata` 0, `load_data_out` 0, `load_valid` 0, `bus_error` 0, counter 0. `stall` is therefore 0 during reset.
- Cycle 0 (IDLE, request): `stall` = 1.
- Cycle 1: WAIT, `bus_req` = 1.
- Ack sampled in WAIT cycle k (k ≥ 1, i.e. cycle k): DONE in cycle k+1 with `load_valid` = 1 and `stall` = 0.
- Stall length is k+1 cycles. The minimum access is 3 cycles (stall 2).
- Timeout access: `stall` = 1 for TIMEOUT_CYCLES+1 cycles, then the DONE cycle.
- Back-to-back accesses: the next request is recognized in the IDLE cycle after DONE. There is always at least one non-stalled cycle (DONE) between accesses.
- Reset mid-WAIT: `bus_req` drops immediately (asynchronously). No `load_valid` is produced.

## Test plan
- Reset idle: `reset` = 1 with random inputs → all outputs 0; after release with no request, `stall` = 0 indefinitely.
- Load, ack in first WAIT cycle: `mem_read_in` = 1, address 0x100, `bus_rdata` = 0xDEADBEEF → `stall` high 2 cycles, `bus_addr` = 0x100, `bus_we` = 0, then `load_valid` pulse with `load_data_out` = 0xDEADBEEF.
- Store with 3-cycle ack delay: `mem_write_in` = 1, address 0x20, data 0x12345678 → `bus_req` held 3 cycles with stable address and data, `stall` high 4 cycles, `load_valid` pulse, `load_data_out` unchanged.
- Timeout, TIMEOUT_CYCLES = 4, no ack → `bus_req` high 4 cycles, `bus_error` = 1 sticky, `load_data_out` = 0; a following load acked normally completes while `bus_error` remains 1.
- Ack on the last allowed WAIT cycle (cycle 4 with TIMEOUT_CYCLES = 4) → normal completion, `bus_error` stays 0.
- Simultaneous read and write → `bus_we` = 1. Asserting `reset` in the middle of WAIT → `bus_req` = 0 immediately, and no `load_valid` pulse follows.
